// File: rtl/sft_pkg.sv
// Shared op and state encodings for the shift register and its command sequencer.
package sft_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_CLR  = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
  localparam logic [OP_W-1:0] OP_SRL  = 3'd2;
  localparam logic [OP_W-1:0] OP_SLL  = 3'd3;
  localparam logic [OP_W-1:0] OP_SRA  = 3'd4;
  localparam logic [OP_W-1:0] OP_SRF  = 3'd5;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd6;
  localparam logic [OP_W-1:0] OP_ROL  = 3'd7;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/sft_reg.sv
// Op-coded shift register with no hold op and no reset; its controller must clear and reload it.
// Every op takes effect on the next clock edge.
module sft_reg
  import sft_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_in,
  input  logic              i_left,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    case (i_op)
      OP_CLR:  r_q <= '0;
      OP_LOAD: r_q <= i_in;
      OP_SRL:  r_q <= {1'b0, r_q[DATA_W-1:1]};
      OP_SLL:  r_q <= {r_q[DATA_W-2:0], 1'b0};
      OP_SRA:  r_q <= {r_q[DATA_W-1], r_q[DATA_W-1:1]};
      OP_SRF:  r_q <= {i_left, r_q[DATA_W-1:1]};
      OP_ROR:  r_q <= {r_q[0], r_q[DATA_W-1:1]};
      OP_ROL:  r_q <= {r_q[DATA_W-2:0], r_q[DATA_W-1]};
    endcase
  end

  assign o_q = r_q;
endmodule

// File: rtl/sft_seq_ctrl.sv
// Command sequencer: load, repeat one shift op amt times, present result; res_valid 1+eff_amt clocks after accept.
// Stalls in DONE until res_ready; no command is taken until the following IDLE cycle.
module sft_seq_ctrl
  import sft_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [2:0]        cmd_mode,
  input  logic [AMT_W-1:0]  cmd_amt,
  input  logic              cmd_fill,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic [2:0]        sr_op,
  output logic [DATA_W-1:0] sr_in,
  output logic              sr_left,
  input  logic [DATA_W-1:0] sr_q
);
  state_t             r_state;
  logic [DATA_W-1:0]  r_data;
  logic [2:0]         r_mode;
  logic [AMT_W-1:0]   r_amt;
  logic               r_fill;
  logic [AMT_W-1:0]   r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_data  <= '0;
      r_mode  <= '0;
      r_amt   <= '0;
      r_fill  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (cmd_valid) begin
            r_data  <= cmd_data;
            r_mode  <= cmd_mode;
            r_amt   <= cmd_amt;
            r_fill  <= cmd_fill;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Clear and load are complete after the load cycle; the amount is meaningless for them.
          if (r_mode <= OP_LOAD || r_amt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_amt;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // The register has no hold op, so idle states reload its own output.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    sr_op     = OP_LOAD;
    sr_in     = sr_q;
    case (r_state)
      ST_INIT: begin
        sr_op = OP_CLR;
        sr_in = '0;
      end
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: begin
        sr_op = (r_mode == OP_CLR) ? OP_CLR : OP_LOAD;
        sr_in = r_data;
      end
      ST_SHIFT: sr_op = r_mode;
      ST_DONE:  res_valid = 1'b1;
      default: begin
        sr_op = OP_CLR;
        sr_in = '0;
      end
    endcase
  end

  assign busy     = !cmd_ready;
  assign res_data = sr_q;
  assign sr_left  = (r_state == ST_INIT) ? 1'b0 : r_fill;
endmodule

// File: tb/tb_sft_seq_ctrl.sv
// Bench for sft_seq_ctrl wired to one sft_reg: directed table, reset/stall sequences, random commands.
module tb_sft_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic [2:0] cmd_mode = 3'd0;
  logic [2:0] cmd_amt = 3'd0;
  logic       cmd_fill = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       busy;
  logic [2:0] sr_op;
  logic [7:0] sr_in;
  logic       sr_left;
  logic [7:0] sr_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sft_seq_ctrl #(.DATA_W(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_mode(cmd_mode), .cmd_amt(cmd_amt), .cmd_fill(cmd_fill),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .sr_op(sr_op), .sr_in(sr_in), .sr_left(sr_left), .sr_q(sr_q)
  );

  sft_reg #(.DATA_W(8)) u_reg (
    .clk(clk), .i_op(sr_op), .i_in(sr_in), .i_left(sr_left), .o_q(sr_q)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: apply the named shift amt times to a plain integer value.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] m,
                                       input logic [2:0] a, input logic f);
    int v;
    v = d;
    if (m == 3'd0) return 8'h00;
    if (m == 3'd1) return d;
    for (int i = 0; i < a; i++) begin
      case (m)
        3'd2: v = v / 2;
        3'd3: v = (v * 2) % 256;
        3'd4: v = (v / 2) + (v >= 128 ? 128 : 0);
        3'd5: v = (v / 2) + (f ? 128 : 0);
        3'd6: v = (v / 2) + ((v % 2) * 128);
        default: v = ((v * 2) % 256) + (v / 128);
      endcase
    end
    return v[7:0];
  endfunction

  function automatic int model_lat(input logic [2:0] m, input logic [2:0] a);
    return (m <= 3'd1 || a == 3'd0) ? 1 : 1 + int'(a);
  endfunction

  // Issue one command, wait for the result, stall it, and retire it with a junk command pending.
  task automatic run_cmd(input string nm, input logic [7:0] d, input logic [2:0] m,
                         input logic [2:0] a, input logic f, input int stall);
    logic [7:0] exp;
    int w, lat;
    exp = model(d, m, a, f);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({nm, " cmd_ready wait"}, cmd_ready, 1'b1);
    if (!cmd_ready) return;
    cmd_data = d; cmd_mode = m; cmd_amt = a; cmd_fill = f; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data = 8'($urandom); cmd_mode = 3'($urandom); cmd_amt = 3'($urandom); cmd_fill = 1'($urandom);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid && cmd_ready) check({nm, " valid/ready exclusive"}, 1'b1, 1'b0);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      check({nm, " res_valid timeout"}, 1'b0, 1'b1);
      return;
    end
    check({nm, " latency"}, lat, model_lat(m, a));
    check({nm, " res_data"}, res_data, exp);
    check({nm, " sr_left"}, sr_left, f);
    check({nm, " busy in done"}, {busy, cmd_ready}, 2'b10);
    cmd_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({nm, " stall res_data"}, res_data, exp);
      check({nm, " stall sr_q"}, sr_q, exp);
      check({nm, " stall flags"}, {res_valid, cmd_ready}, 2'b10);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check({nm, " no accept in done"}, {cmd_ready, res_valid, busy}, 3'b100);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] mode;
    logic [2:0] amt;
    logic       fill;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'hB4, 3'd2, 3'd3, 1'b0, 8'h16, 4};
    vt[1] = '{8'h96, 3'd4, 3'd2, 1'b0, 8'hE5, 3};
    vt[2] = '{8'h81, 3'd7, 3'd1, 1'b0, 8'h03, 2};
    vt[3] = '{8'h81, 3'd6, 3'd1, 1'b0, 8'hC0, 2};
    vt[4] = '{8'h00, 3'd5, 3'd3, 1'b1, 8'hE0, 4};
    vt[5] = '{8'h5A, 3'd3, 3'd0, 1'b0, 8'h5A, 1};
    vt[6] = '{8'hFF, 3'd0, 3'd5, 1'b0, 8'h00, 1};

    // Reset and INIT behaviour.
    repeat (3) @(negedge clk);
    check("reset outputs", {cmd_ready, res_valid, busy, sr_op, sr_in, sr_left},
          {1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0});
    rst = 1'b0;
    #1;
    check("init cycle", {cmd_ready, busy, sr_op}, {1'b0, 1'b1, 3'd0});
    @(negedge clk);
    check("idle after init", {cmd_ready, busy, sr_q}, {1'b1, 1'b0, 8'h00});
    repeat (10) @(negedge clk);
    check("idle hold", {cmd_ready, sr_op, sr_q}, {1'b1, 3'd1, 8'h00});

    // Directed vectors; the table's expectations are cross-checked against the model too.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("vec%0d model", i), model(vt[i].data, vt[i].mode, vt[i].amt, vt[i].fill), vt[i].exp);
      check($sformatf("vec%0d model lat", i), model_lat(vt[i].mode, vt[i].amt), vt[i].lat);
      run_cmd($sformatf("vec%0d", i), vt[i].data, vt[i].mode, vt[i].amt, vt[i].fill, 0);
    end

    // Long stall in DONE with a command waiting.
    run_cmd("stall6", 8'h3C, 3'd3, 3'd2, 1'b0, 6);

    // Reset during SHIFT after two shift ops.
    while (!cmd_ready) @(negedge clk);
    cmd_data = 8'hF0; cmd_mode = 3'd2; cmd_amt = 3'd7; cmd_fill = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-shift value", sr_q, model(8'hF0, 3'd2, 3'd2, 1'b0));
    check("mid-shift busy", {busy, res_valid}, 2'b10);
    rst = 1'b1;
    #1;
    check("abort outputs", {res_valid, cmd_ready, busy, sr_op}, {1'b0, 1'b0, 1'b1, 3'd0});
    @(negedge clk);
    check("abort clears reg", sr_q, 8'h00);
    rst = 1'b0;
    run_cmd("after reset", vt[0].data, vt[0].mode, vt[0].amt, vt[0].fill, 1);

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      run_cmd($sformatf("rand%0d", i), 8'($urandom), 3'($urandom), 3'($urandom),
              1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
